// File: rtl/alu_muldiv_control.sv
// alu_muldiv_control: EX-stage ALU op decode plus background radix-2 mul/div sequencer with HI/LO
//   i_clk, i_rst          : clock, async active-high reset
//   i_valid               : EX holds a real instruction
//   i_alu_op_CU           : ALUOp from control unit
//   i_op_r_tipe           : funct field
//   i_rs_data, i_rt_data  : operands (dividend/multiplicand/MT source, divisor/multiplier)
//   o_alu_control_signals : decoded ALU op code
//   o_result, o_result_sel: HI/LO read value for MFHI/MFLO and its writeback select
//   o_stall               : hold IF/ID/EX while a HI/LO consumer or mul/div waits on the sequencer
//   o_busy                : sequencer not idle
module alu_muldiv_control #(
    parameter int NB_DATA   = 32,
    parameter int NB_FUNCT  = 6,
    parameter int NB_ALU_OP = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [NB_ALU_OP-1:0] i_alu_op_CU,
    input  logic [NB_FUNCT-1:0]  i_op_r_tipe,
    input  logic [NB_DATA-1:0]   i_rs_data,
    input  logic [NB_DATA-1:0]   i_rt_data,
    output logic [NB_FUNCT-1:0]  o_alu_control_signals,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_result_sel,
    output logic                 o_stall,
    output logic                 o_busy
);
    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_FUNCT-1:0] F_MULT  = NB_FUNCT'(6'b011000);
    localparam logic [NB_FUNCT-1:0] F_MULTU = NB_FUNCT'(6'b011001);
    localparam logic [NB_FUNCT-1:0] F_DIV   = NB_FUNCT'(6'b011010);
    localparam logic [NB_FUNCT-1:0] F_DIVU  = NB_FUNCT'(6'b011011);
    localparam logic [NB_FUNCT-1:0] F_MFHI  = NB_FUNCT'(6'b010000);
    localparam logic [NB_FUNCT-1:0] F_MTHI  = NB_FUNCT'(6'b010001);
    localparam logic [NB_FUNCT-1:0] F_MFLO  = NB_FUNCT'(6'b010010);
    localparam logic [NB_FUNCT-1:0] F_MTLO  = NB_FUNCT'(6'b010011);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t              r_state;
    logic [NB_CNT-1:0]   r_cnt;
    logic [NB_DATA-1:0]  r_hi, r_lo;
    // r_a:r_b is the product accumulator (multiply) or remainder:quotient (divide); r_m is the addend/divisor
    logic [NB_DATA-1:0]  r_a, r_b, r_m;
    logic                r_div, r_neg_q, r_neg_r, r_busy;

    logic                w_class, w_present, w_accept, w_muldiv, w_is_div, w_signed;
    logic                w_rs_neg, w_rt_neg, w_mfhi, w_mflo;
    logic [NB_DATA-1:0]  w_rs_mag, w_rt_mag, w_sub, w_quo, w_rem;
    logic [NB_DATA:0]    w_add, w_sh;
    logic                w_ge;
    logic [2*NB_DATA-1:0] w_prod;

    assign w_class   = i_op_r_tipe inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
    assign w_present = i_valid & (i_alu_op_CU == NB_ALU_OP'(4'b0010)) & w_class;
    assign w_accept  = w_present & ~r_busy;
    assign o_stall   = w_present & r_busy;
    assign o_busy    = r_busy;

    assign w_muldiv = i_op_r_tipe inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    assign w_is_div = i_op_r_tipe inside {F_DIV, F_DIVU};
    assign w_signed = i_op_r_tipe inside {F_MULT, F_DIV};
    assign w_rs_neg = w_signed & i_rs_data[NB_DATA-1];
    assign w_rt_neg = w_signed & i_rt_data[NB_DATA-1];
    assign w_rs_mag = w_rs_neg ? -i_rs_data : i_rs_data;
    assign w_rt_mag = w_rt_neg ? -i_rt_data : i_rt_data;

    assign w_mfhi       = w_accept & (i_op_r_tipe == F_MFHI);
    assign w_mflo       = w_accept & (i_op_r_tipe == F_MFLO);
    assign o_result_sel = w_mfhi | w_mflo;
    assign o_result     = w_mfhi ? r_hi : w_mflo ? r_lo : '0;

    // Multiply step: conditional add of the multiplicand into the upper half, then shift right
    assign w_add = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : '0);
    // Divide step: shift next dividend bit into the remainder, subtract divisor if it fits
    assign w_sh  = {r_a, r_b[NB_DATA-1]};
    assign w_ge  = w_sh >= {1'b0, r_m};
    assign w_sub = w_sh[NB_DATA-1:0] - r_m;

    assign w_prod = r_neg_q ? -{r_a, r_b} : {r_a, r_b};
    assign w_quo  = r_neg_q ? -r_b : r_b;
    assign w_rem  = r_neg_r ? -r_a : r_a;

    always_comb begin
        o_alu_control_signals = 6'b100000;
        case (i_alu_op_CU)
            4'b0001: o_alu_control_signals = 6'b100001;
            4'b0100: o_alu_control_signals = 6'b100100;
            4'b0101: o_alu_control_signals = 6'b100101;
            4'b1000: o_alu_control_signals = 6'b100110;
            4'b1001: o_alu_control_signals = 6'b001111;
            4'b1100: o_alu_control_signals = 6'b101010;
            4'b1101: o_alu_control_signals = 6'b101011;
            4'b0111: o_alu_control_signals = 6'b100010;
            4'b0010: o_alu_control_signals = w_class ? 6'b100001 : i_op_r_tipe;
            default: o_alu_control_signals = 6'b100000;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && i_op_r_tipe == F_MTHI) r_hi <= i_rs_data;
                    if (w_accept && i_op_r_tipe == F_MTLO) r_lo <= i_rs_data;
                    if (w_accept && w_muldiv) begin
                        r_div  <= w_is_div;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (w_is_div && i_rt_data == '0) begin
                            // Divide by zero skips iteration; FIX writes the preset values unchanged
                            r_state <= S_FIX;
                            r_a     <= i_rs_data;
                            r_b     <= '1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                            r_a     <= '0;
                            r_b     <= w_is_div ? w_rs_mag : w_rt_mag;
                            r_m     <= w_is_div ? w_rt_mag : w_rs_mag;
                            r_neg_q <= w_rs_neg ^ w_rt_neg;
                            r_neg_r <= w_rs_neg;
                        end
                    end
                end
                S_RUN: begin
                    if (r_div) begin
                        r_a <= w_ge ? w_sub : w_sh[NB_DATA-1:0];
                        r_b <= {r_b[NB_DATA-2:0], w_ge};
                    end else begin
                        r_a <= w_add[NB_DATA:1];
                        r_b <= {w_add[0], r_b[NB_DATA-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == NB_CNT'(NB_DATA - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    {r_hi, r_lo} <= r_div ? {w_rem, w_quo} : w_prod;
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_control.sv
// tb_alu_muldiv_control: randomized scoreboard bench for alu_muldiv_control against an arithmetic HI/LO model
module tb_alu_muldiv_control;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;

    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0;
    logic [3:0]  i_alu_op_CU = 4'b0010;
    logic [5:0]  i_op_r_tipe = '0;
    logic [31:0] i_rs_data = '0, i_rt_data = '0;
    logic [5:0]  o_alu_control_signals;
    logic [31:0] o_result;
    logic        o_result_sel, o_stall, o_busy;

    int n_chk = 0, n_pass = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] exp_q[$];

    alu_muldiv_control dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_alu_op_CU(i_alu_op_CU),
        .i_op_r_tipe(i_op_r_tipe), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .o_alu_control_signals(o_alu_control_signals), .o_result(o_result),
        .o_result_sel(o_result_sel), .o_stall(o_stall), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] exp_dec(input logic [3:0] op, input logic [5:0] f);
        if (op == 4'b0010) return (f inside {MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO}) ? 6'b100001 : f;
        case (op)
            4'b0001: return 6'b100001;
            4'b0100: return 6'b100100;
            4'b0101: return 6'b100101;
            4'b1000: return 6'b100110;
            4'b1001: return 6'b001111;
            4'b1100: return 6'b101010;
            4'b1101: return 6'b101011;
            4'b0111: return 6'b100010;
            default: return 6'b100000;
        endcase
    endfunction

    // Program-order model: every op takes effect instantly, so a later MF sees the finished result
    task automatic model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        longint p, q, r;
        logic [63:0] u;
        case (f)
            MULT: begin
                p = longint'($signed(rs)) * longint'($signed(rt));
                {m_hi, m_lo} = p;
            end
            MULTU: begin
                u = {32'b0, rs} * {32'b0, rt};
                {m_hi, m_lo} = u;
            end
            DIV: begin
                if (rt == 0) begin
                    m_lo = '1;
                    m_hi = rs;
                end else begin
                    q = longint'($signed(rs)) / longint'($signed(rt));
                    r = longint'($signed(rs)) % longint'($signed(rt));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            DIVU: begin
                m_lo = (rt == 0) ? 32'hFFFF_FFFF : rs / rt;
                m_hi = (rt == 0) ? rs : rs % rt;
            end
            MFHI: exp_q.push_back(m_hi);
            MFLO: exp_q.push_back(m_lo);
            MTHI: m_hi = rs;
            MTLO: m_lo = rs;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt, output int stalls);
        i_valid = 1'b1;
        i_alu_op_CU = 4'b0010;
        i_op_r_tipe = f;
        i_rs_data = rs;
        i_rt_data = rt;
        model(f, rs, rt);
        stalls = 0;
        @(negedge i_clk);
        while (o_stall && stalls < 200) begin
            stalls++;
            @(negedge i_clk);
        end
        if (stalls >= 200) begin
            n_chk++;
            $display("FAIL issue_timeout: funct %b still stalled after %0d cycles", f, stalls);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_op_r_tipe = '0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (o_busy && cnt < 200) begin
            cnt++;
            @(posedge i_clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom_range(0, 20);
        endcase
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst && o_result_sel) begin
            if (exp_q.size() == 0) chk("unexpected_result_sel", {32'b0, o_result}, 64'hDEAD_0000_0000_0000);
            else chk("mf_result", {32'b0, o_result}, {32'b0, exp_q.pop_front()});
        end
    end

    initial begin
        int s, c;
        logic [5:0] f;
        logic [31:0] rs, rt;
        i_valid = 1'b1;
        i_op_r_tipe = MULT;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_busy", o_busy, 0);
        chk("reset_stall", o_stall, 0);
        chk("reset_result", o_result, 0);
        chk("reset_decode", o_alu_control_signals, 6'b100001);
        i_valid = 1'b0;
        i_rst = 1'b0;
        for (int op = 0; op < 16; op++) begin
            i_alu_op_CU = op[3:0];
            i_op_r_tipe = $urandom;
            #1;
            chk("decode_table", o_alu_control_signals, exp_dec(op[3:0], i_op_r_tipe));
        end
        i_alu_op_CU = 4'b0010; i_op_r_tipe = 6'b101010; #1;
        chk("decode_pass_slt", o_alu_control_signals, 6'b101010);
        i_alu_op_CU = 4'b1101; #1;
        chk("decode_sltu", o_alu_control_signals, 6'b101011);
        i_alu_op_CU = 4'b0010; i_op_r_tipe = MULT; #1;
        chk("decode_mult_class", o_alu_control_signals, 6'b100001);
        @(posedge i_clk);
        #1;
        issue(MFHI, 0, 0, s);
        issue(MFLO, 0, 0, s);
        issue(MULT, 7, -32'sd3, s);
        chk("mult_no_self_stall", s, 0);
        wait_idle(c);
        chk("mult_busy_cycles", c, 33);
        issue(MFHI, 0, 0, s);
        issue(MFLO, 0, 0, s);
        issue(DIVU, 100, 7, s);
        issue(MFLO, 0, 0, s);
        issue(MFHI, 0, 0, s);
        issue(DIV, -32'sd7, 2, s);
        issue(MFLO, 0, 0, s);
        issue(MFHI, 0, 0, s);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
        issue(MFLO, 0, 0, s);
        issue(MFHI, 0, 0, s);
        issue(MULT, 5, 6, s);
        @(posedge i_clk);
        #1;
        issue(MFLO, 0, 0, s);
        chk("mflo_stall_cycles", s, 32);
        issue(DIV, 9, 0, s);
        wait_idle(c);
        chk("div0_busy_cycles", c, 1);
        issue(MFLO, 0, 0, s);
        issue(MFHI, 0, 0, s);
        issue(MTLO, 32'h1234, 0, s);
        issue(MFLO, 0, 0, s);
        issue(MULT, 32'h1234_5678, 32'h9ABC_DEF0, s);
        issue(MTHI, 32'hDEAD, 0, s);
        chk("mthi_back_to_back_stall", s, 33);
        issue(MFHI, 0, 0, s);
        issue(MFLO, 0, 0, s);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        repeat (10) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        chk("reset_abort_busy", o_busy, 0);
        m_hi = '0;
        m_lo = '0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        issue(MFHI, 0, 0, s);
        issue(MFLO, 0, 0, s);
        issue(MULTU, 3, 4, s);
        issue(MFLO, 0, 0, s);
        for (int k = 0; k < 100; k++) begin
            rs = pick();
            rt = pick();
            case ($urandom_range(0, 11))
                0, 1, 2, 3: begin
                    f = MULT + 6'($urandom_range(0, 3));
                    if (f inside {DIV, DIVU} && $urandom_range(0, 4) == 0) rt = '0;
                    issue(f, rs, rt, s);
                end
                4, 5, 6, 7: issue(MFHI + 6'($urandom_range(0, 3)), rs, rt, s);
                8, 9, 10: begin
                    i_valid = ($urandom_range(0, 2) != 0);
                    i_alu_op_CU = i_valid ? (($urandom_range(0, 1) != 0) ? 4'b0000 : 4'b0010) : 4'b0010;
                    i_op_r_tipe = (i_alu_op_CU == 4'b0010 && i_valid) ? 6'b100000 : MTHI + 6'($urandom_range(0, 2) * 2);
                    i_rs_data = rs;
                    i_rt_data = rt;
                    @(posedge i_clk);
                    #1;
                    i_valid = 1'b0;
                    i_alu_op_CU = 4'b0010;
                    i_op_r_tipe = '0;
                end
                default: repeat ($urandom_range(1, 40)) @(posedge i_clk);
            endcase
        end
        issue(MFHI, 0, 0, s);
        issue(MFLO, 0, 0, s);
        wait_idle(c);
        repeat (3) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
